// File: rtl/pokemon_pkg.sv
// Shared phase encodings, winner codes and defaults for the Pokemon match sequencer.
package pokemon_pkg;

   typedef enum logic [2:0] {
      PH_IDLE       = 3'd0,
      PH_ROUND_INIT = 3'd1,
      PH_COUNTDOWN  = 3'd2,
      PH_PLAY       = 3'd3,
      PH_KO_HOLD    = 3'd4,
      PH_MATCH_OVER = 3'd5
   } phase_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2,
      WIN_DRAW = 2'd3
   } winner_t;

   localparam logic [3:0]  GAME_STATE_DEF = 4'b0010;
   localparam int unsigned TMR_W          = 8;

   function automatic winner_t winner_code(input logic [1:0] w1, input logic [1:0] w2);
      if (w1 > w2)      return WIN_P1;
      else if (w2 > w1) return WIN_P2;
      else              return WIN_DRAW;
   endfunction

endpackage

// File: rtl/pokemon_tick_timer.sv
// Tick/second counter pair: counts load_secs periods of load_period ticks, pulses done on the last tick.
module pokemon_tick_timer
   import pokemon_pkg::*;
#(
   parameter int unsigned CNT_W = TMR_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [1:0]       load_secs_i,
   input  logic [CNT_W-1:0] load_period_i,
   input  logic             tick_i,
   output logic [1:0]       secs_nxt_o,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [1:0]       secs_q, secs_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         period_q <= '0;
         secs_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         secs_q   <= secs_d;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      secs_d   = secs_q;
      done_o   = 1'b0;
      if (clear_i) begin
         cnt_d    = '0;
         period_d = '0;
         secs_d   = '0;
      end else if (load_i) begin
         cnt_d    = '0;
         period_d = load_period_i;
         secs_d   = load_secs_i;
      end else if (tick_i && (secs_q != 2'd0)) begin
         if (cnt_q == period_q - CNT_W'(1)) begin
            cnt_d  = '0;
            secs_d = secs_q - 2'd1;
            done_o = (secs_q == 2'd1);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Next-state count lets the parent register its displayed value without an extra cycle of lag.
   assign secs_nxt_o = secs_d;

endmodule

// File: rtl/pokemon_match_sequencer.sv
// Best-of-N match sequencer: round resets, pre-round countdown, gameplay gating, KO detection and scoring.
module pokemon_match_sequencer
   import pokemon_pkg::*;
#(
   parameter logic [3:0]  GAME_STATE    = GAME_STATE_DEF,
   parameter int unsigned WINS_NEEDED   = 2,
   parameter int unsigned MAX_ROUNDS    = 5,
   parameter int unsigned COUNT_SECS    = 3,
   parameter int unsigned TICKS_PER_SEC = 20,
   parameter int unsigned KO_TICKS      = 40
) (
   input  logic       single_pulse_clk,
   input  logic       reset,
   input  logic [3:0] state,
   input  logic       start_btn,
   input  logic       tick_20Hz,
   input  logic       charmander_alive,
   input  logic       squirtle_alive,
   output logic       round_reset,
   output logic       game_enable,
   output logic [1:0] countdown_value,
   output logic [2:0] round_num,
   output logic [1:0] wins_p1,
   output logic [1:0] wins_p2,
   output logic [2:0] phase,
   output logic       ended,
   output logic [1:0] winner
);

   localparam logic [1:0]       WN = 2'(WINS_NEEDED);
   localparam logic [2:0]       MR = 3'(MAX_ROUNDS);
   localparam logic [1:0]       CS = 2'(COUNT_SECS);
   localparam logic [TMR_W-1:0] TP = TMR_W'(TICKS_PER_SEC);
   localparam logic [TMR_W-1:0] KT = TMR_W'(KO_TICKS);

   phase_t     state_q, state_d;
   logic [1:0] wins_p1_q, wins_p1_d;
   logic [1:0] wins_p2_q, wins_p2_d;
   logic [2:0] round_q, round_d;
   logic       round_reset_q, game_enable_q, ended_q;
   logic [1:0] cd_q, cd_d;
   winner_t    winner_q, winner_d;

   logic             tmr_clear, tmr_load, tmr_tick, tmr_done;
   logic [1:0]       tmr_load_secs, tmr_secs_nxt;
   logic [TMR_W-1:0] tmr_load_period;

   assign tmr_tick = tick_20Hz && ((state_q == PH_COUNTDOWN) || (state_q == PH_KO_HOLD));

   pokemon_tick_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .clk_i         (single_pulse_clk),
      .rst_i         (reset),
      .clear_i       (tmr_clear),
      .load_i        (tmr_load),
      .load_secs_i   (tmr_load_secs),
      .load_period_i (tmr_load_period),
      .tick_i        (tmr_tick),
      .secs_nxt_o    (tmr_secs_nxt),
      .done_o        (tmr_done)
   );

   always_ff @(posedge single_pulse_clk or posedge reset) begin
      if (reset) begin
         state_q       <= PH_IDLE;
         wins_p1_q     <= '0;
         wins_p2_q     <= '0;
         round_q       <= '0;
         round_reset_q <= 1'b0;
         game_enable_q <= 1'b0;
         ended_q       <= 1'b0;
         cd_q          <= '0;
         winner_q      <= WIN_NONE;
      end else begin
         state_q       <= state_d;
         wins_p1_q     <= wins_p1_d;
         wins_p2_q     <= wins_p2_d;
         round_q       <= round_d;
         round_reset_q <= (state_d == PH_ROUND_INIT);
         game_enable_q <= (state_d == PH_PLAY);
         ended_q       <= (state_d == PH_MATCH_OVER);
         cd_q          <= cd_d;
         winner_q      <= winner_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      wins_p1_d       = wins_p1_q;
      wins_p2_d       = wins_p2_q;
      round_d         = round_q;
      tmr_clear       = 1'b0;
      tmr_load        = 1'b0;
      tmr_load_secs   = '0;
      tmr_load_period = '0;

      unique case (state_q)
         PH_IDLE: begin
            wins_p1_d = '0;
            wins_p2_d = '0;
            round_d   = '0;
            if (start_btn && (state == GAME_STATE)) begin
               round_d = 3'd1;
               state_d = PH_ROUND_INIT;
            end
         end
         PH_ROUND_INIT: begin
            tmr_load        = 1'b1;
            tmr_load_secs   = CS;
            tmr_load_period = TP;
            state_d         = PH_COUNTDOWN;
         end
         PH_COUNTDOWN: begin
            if (tmr_done) state_d = PH_PLAY;
         end
         PH_PLAY: begin
            if (!charmander_alive || !squirtle_alive) begin
               if (charmander_alive && (wins_p1_q != WN)) wins_p1_d = wins_p1_q + 2'd1;
               if (squirtle_alive && (wins_p2_q != WN))   wins_p2_d = wins_p2_q + 2'd1;
               // KO_HOLD reuses the timer as a single "second" of KO_TICKS ticks.
               tmr_load        = 1'b1;
               tmr_load_secs   = 2'd1;
               tmr_load_period = KT;
               state_d         = PH_KO_HOLD;
            end
         end
         PH_KO_HOLD: begin
            if (tmr_done) begin
               if ((wins_p1_q == WN) || (wins_p2_q == WN) || (round_q == MR)) begin
                  state_d = PH_MATCH_OVER;
               end else begin
                  round_d = round_q + 3'd1;
                  state_d = PH_ROUND_INIT;
               end
            end
         end
         PH_MATCH_OVER: ;
         default: state_d = PH_IDLE;
      endcase

      if ((state_q != PH_IDLE) && (state != GAME_STATE)) begin
         state_d   = PH_IDLE;
         wins_p1_d = '0;
         wins_p2_d = '0;
         round_d   = '0;
         tmr_clear = 1'b1;
         tmr_load  = 1'b0;
      end

      cd_d     = (state_d == PH_COUNTDOWN) ? tmr_secs_nxt : 2'd0;
      winner_d = (state_d == PH_MATCH_OVER) ? winner_code(wins_p1_d, wins_p2_d) : WIN_NONE;
   end

   assign round_reset     = round_reset_q;
   assign game_enable     = game_enable_q;
   assign countdown_value = cd_q;
   assign round_num       = round_q;
   assign wins_p1         = wins_p1_q;
   assign wins_p2         = wins_p2_q;
   assign phase           = state_q;
   assign ended           = ended_q;
   assign winner          = winner_q;

endmodule

// File: tb/tb_pokemon_match_sequencer.sv
// Scoreboard bench for pokemon_match_sequencer: expected output snapshots are queued as stimulus is driven.
module tb_pokemon_match_sequencer;

   localparam logic [3:0] GS = 4'b0010;

   typedef struct packed {
      logic [2:0] ph;
      logic       rr;
      logic       ge;
      logic [1:0] cd;
      logic [2:0] rnd;
      logic [1:0] w1;
      logic [1:0] w2;
      logic       en;
      logic [1:0] win;
   } snap_t;

   logic       clk = 1'b0;
   logic       reset, start_btn, tick, ca, sa;
   logic [3:0] state;
   logic       round_reset, game_enable, ended;
   logic [1:0] countdown_value, wins_p1, wins_p2, winner;
   logic [2:0] round_num, phase;

   snap_t snap, e;
   snap_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   pokemon_match_sequencer dut (
      .single_pulse_clk (clk),
      .reset            (reset),
      .state            (state),
      .start_btn        (start_btn),
      .tick_20Hz        (tick),
      .charmander_alive (ca),
      .squirtle_alive   (sa),
      .round_reset      (round_reset),
      .game_enable      (game_enable),
      .countdown_value  (countdown_value),
      .round_num        (round_num),
      .wins_p1          (wins_p1),
      .wins_p2          (wins_p2),
      .phase            (phase),
      .ended            (ended),
      .winner           (winner)
   );

   always #5 clk = ~clk;

   assign snap = {phase, round_reset, game_enable, countdown_value, round_num,
                  wins_p1, wins_p2, ended, winner};

   // Expected snapshot derived from phase and counters as the behaviour describes.
   function automatic snap_t mk(input int ph, input int rnd, input int w1, input int w2, input int cd);
      snap_t s;
      s.ph  = 3'(ph);
      s.rr  = (ph == 1);
      s.ge  = (ph == 3);
      s.cd  = (ph == 2) ? 2'(cd) : 2'd0;
      s.rnd = 3'(rnd);
      s.w1  = 2'(w1);
      s.w2  = 2'(w2);
      s.en  = (ph == 5);
      s.win = (ph != 5) ? 2'd0 : (w1 > w2) ? 2'd1 : (w2 > w1) ? 2'd2 : 2'd3;
      return s;
   endfunction

   task automatic step;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step();
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL reset_state: actual=%h required=%h", snap, e);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic start_round(input string nm);
      state     = GS;
      start_btn = 1'b1;
      exp_q.push_back(mk(1, 1, 0, 0, 0));
      step();
      start_btn = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL %s_init: actual=%h required=%h", nm, snap, e);
      end
      exp_q.push_back(mk(2, 1, 0, 0, 3));
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL %s_cd_start: actual=%h required=%h", nm, snap, e);
      end
   endtask

   task automatic run_countdown(input string nm, input int rnd, input int w1, input int w2);
      for (int t = 1; t <= 60; t++) begin
         tick = 1'b1;
         exp_q.push_back((t < 60) ? mk(2, rnd, w1, w2, 3 - t / 20) : mk(3, rnd, w1, w2, 0));
         step();
         tick = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (snap !== e) begin
            n_fail++;
            $display("FAIL %s_tick%0d: actual=%h required=%h", nm, t, snap, e);
         end
         step();
      end
   endtask

   task automatic ko(input string nm, input logic c, input logic s,
                     input int rnd, input int w1, input int w2);
      ca = c;
      sa = s;
      exp_q.push_back(mk(4, rnd, w1, w2, 0));
      step();
      ca = 1'b1;
      sa = 1'b1;
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, snap, e);
      end
   endtask

   task automatic ko_hold(input string nm, input int rnd, input int w1, input int w2, input bit over);
      for (int t = 1; t <= 40; t++) begin
         tick = 1'b1;
         if (t < 40)   exp_q.push_back(mk(4, rnd, w1, w2, 0));
         else if (over) exp_q.push_back(mk(5, rnd, w1, w2, 0));
         else           exp_q.push_back(mk(1, rnd + 1, w1, w2, 0));
         step();
         tick = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (snap !== e) begin
            n_fail++;
            $display("FAIL %s_tick%0d: actual=%h required=%h", nm, t, snap, e);
         end
         if (t == 40 && !over) exp_q.push_back(mk(2, rnd + 1, w1, w2, 3));
         step();
         if (t == 40 && !over) begin
            e = exp_q.pop_front();
            n_checks++;
            if (snap !== e) begin
               n_fail++;
               $display("FAIL %s_next_round: actual=%h required=%h", nm, snap, e);
            end
         end
      end
   endtask

   task automatic test_start_countdown;
      start_round("start");
      run_countdown("cd1", 1, 0, 0);
   endtask

   task automatic test_ko_p1;
      ko("ko_squirtle", 1'b1, 1'b0, 1, 1, 0);
      ko_hold("hold1", 1, 1, 0, 1'b0);
   endtask

   task automatic test_match_p1;
      run_countdown("cd2", 2, 1, 0);
      ko("ko_squirtle2", 1'b1, 1'b0, 2, 2, 0);
      ko_hold("hold2", 2, 2, 0, 1'b1);
      start_btn = 1'b1;
      tick      = 1'b1;
      exp_q.push_back(mk(5, 2, 2, 0, 0));
      step();
      start_btn = 1'b0;
      tick      = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL start_in_over: actual=%h required=%h", snap, e);
      end
   endtask

   task automatic test_abort;
      state = 4'b0001;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL abort_over: actual=%h required=%h", snap, e);
      end
      start_round("restart");
      for (int t = 1; t <= 25; t++) begin
         tick = 1'b1;
         exp_q.push_back(mk(2, 1, 0, 0, 3 - t / 20));
         step();
         tick = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (snap !== e) begin
            n_fail++;
            $display("FAIL partial_cd_tick%0d: actual=%h required=%h", t, snap, e);
         end
      end
      state = 4'b0001;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL abort_countdown: actual=%h required=%h", snap, e);
      end
      tick = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      tick = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL idle_tick: actual=%h required=%h", snap, e);
      end
      state = GS;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL idle_no_start: actual=%h required=%h", snap, e);
      end
      start_round("restart2");
      run_countdown("cd_after_abort", 1, 0, 0);
   endtask

   task automatic test_draws;
      for (int r = 1; r <= 5; r++) begin
         ko("draw_ko", 1'b0, 1'b0, r, 0, 0);
         ko_hold("draw_hold", r, 0, 0, r == 5);
         if (r < 5) run_countdown("draw_cd", r + 1, 0, 0);
      end
      state = 4'b0001;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL abort_after_draws: actual=%h required=%h", snap, e);
      end
      state = GS;
   endtask

   task automatic test_reset_mid_play;
      start_round("rmp");
      run_countdown("rmp_cd1", 1, 0, 0);
      ko("rmp_ko_squirtle", 1'b1, 1'b0, 1, 1, 0);
      ko_hold("rmp_hold1", 1, 1, 0, 1'b0);
      run_countdown("rmp_cd2", 2, 1, 0);
      ko("rmp_ko_charmander", 1'b0, 1'b1, 2, 1, 1);
      ko_hold("rmp_hold2", 2, 1, 1, 1'b0);
      run_countdown("rmp_cd3", 3, 1, 1);
      reset = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (snap !== e) begin
         n_fail++;
         $display("FAIL reset_mid_play: actual=%h required=%h", snap, e);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      reset     = 1'b0;
      state     = 4'b0000;
      start_btn = 1'b0;
      tick      = 1'b0;
      ca        = 1'b1;
      sa        = 1'b1;
      test_reset();
      test_start_countdown();
      test_ko_p1();
      test_match_p1();
      test_abort();
      test_draws();
      test_reset_mid_play();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pokemon_match_sequencer.md
Name: pokemon_match_sequencer

Overview:
- Sequences a best-of-N Pokemon battle on top of the existing game logic, display and segment blocks.
- Sits beside the game logic. It is enabled only while the top-level screen state is the Pokemon game.
- Issues per-round reset pulses, runs a pre-round countdown, gates gameplay, and detects KO from the alive flags.
- Keeps win counts and raises a match-over flag with the winner.

Parameters:
- GAME_STATE, 4'b0010, top-level state code meaning "Pokemon game on screen".
- WINS_NEEDED, 2, round wins required to take the match (1..3).
- MAX_ROUNDS, 5, hard round limit, counting draws (1..7).
- COUNT_SECS, 3, countdown length in seconds (1..3).
- TICKS_PER_SEC, 20, tick_20Hz pulses per second.
- KO_TICKS, 40, length of the post-KO freeze in ticks.

Ports:
- single_pulse_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- state  in  4  top-level screen state
- start_btn  in  1  single-cycle start pulse
- tick_20Hz  in  1  single-cycle enable at 20 Hz, synchronous to single_pulse_clk
- charmander_alive  in  1  player 1 alive flag from game logic
- squirtle_alive  in  1  player 2 alive flag from game logic
- round_reset  out  1  one-cycle pulse that clears health, projectiles and shields in game logic
- game_enable  out  1  high only in PLAY; game logic ignores moves and shots when low
- countdown_value  out  2  seconds remaining (3..1), 0 outside COUNTDOWN
- round_num  out  3  current round, 1-based; 0 in IDLE
- wins_p1  out  2  rounds won by Charmander
- wins_p2  out  2  rounds won by Squirtle
- phase  out  3  encoded FSM state
- ended  out  1  high in MATCH_OVER
- winner  out  2  0 none, 1 Charmander, 2 Squirtle, 3 draw

Behaviour:
- Reset (async, any state): FSM goes to IDLE.
  - All outputs 0; all counters 0.
- FSM states (phase encoding): IDLE=0, ROUND_INIT=1, COUNTDOWN=2, PLAY=3, KO_HOLD=4, MATCH_OVER=5.
- Abort rule: in any state other than IDLE, if state != GAME_STATE, go to IDLE next cycle.
  - Counters, wins, round_num, winner and ended are cleared.
  - Abort has priority over every other transition.
- IDLE:
  - start_btn && state==GAME_STATE → ROUND_INIT.
  - wins cleared; round_num set to 1.
- ROUND_INIT: exactly one cycle.
  - round_reset=1 for this cycle only.
  - Loads the second counter with COUNT_SECS and the tick counter with 0.
  - Next state: COUNTDOWN.
- COUNTDOWN:
  - Each tick_20Hz increments the tick counter.
  - When the tick counter reaches TICKS_PER_SEC-1 on a tick, it wraps to 0 and the second counter decrements.
  - When the second counter is 1 and wraps, go to PLAY.
  - countdown_value shows the second counter.
  - Alive flags are ignored.
- PLAY:
  - game_enable=1.
  - Alive flags are sampled every cycle.
  - Both low in the same cycle → draw: no win credited.
  - Only charmander_alive low → wins_p2 += 1.
  - Only squirtle_alive low → wins_p1 += 1.
  - Any KO → KO_HOLD, tick counter cleared.
  - game_enable drops in the cycle after KO is detected (registered output).
- KO_HOLD:
  - Counts KO_TICKS ticks.
  - On the last tick: if wins_p1==WINS_NEEDED, wins_p2==WINS_NEEDED, or round_num==MAX_ROUNDS → MATCH_OVER.
  - Otherwise round_num += 1 → ROUND_INIT.
- MATCH_OVER:
  - ended=1.
  - winner=1 if wins_p1>wins_p2, 2 if wins_p2>wins_p1, 3 if equal.
  - Holds until abort (state leaves GAME_STATE) or reset.
  - start_btn is ignored.
- Win counters saturate at WINS_NEEDED. round_num never exceeds MAX_ROUNDS.
- start_btn outside IDLE is ignored.
- tick_20Hz outside COUNTDOWN and KO_HOLD is ignored.
- All outputs are registered. Latency from KO edge to phase change is 1 cycle.

Decomposition:
- Shared package pokemon_pkg holds:
  - phase encodings (PH_IDLE..PH_MATCH_OVER);
  - winner codes;
  - the GAME_STATE default.
- The tick/second counter pair is a natural sub-module: pokemon_tick_timer.
  - Inputs: load, load value, tick.
  - Outputs: second count, done pulse.
  - Reused for COUNTDOWN and KO_HOLD.

Test Plan:
- Reset mid-PLAY (assert reset with phase=3, wins_p1=1) → immediately phase=0, wins 0, round_num 0, game_enable 0.
- Start pulse with state=GAME_STATE:
  - round_reset high exactly 1 cycle;
  - countdown_value 3→2→1 at 20-tick intervals;
  - game_enable rises after 60 ticks.
- In PLAY, drop squirtle_alive → wins_p1=1, phase=4.
  - After 40 ticks, round_num=2 and round_reset pulses again.
- Charmander wins 2 rounds → phase=5, ended=1, winner=1. A start_btn pulse afterwards changes nothing.
- Both alive flags drop in the same cycle, 5 times → wins stay 0, round_num reaches 5, then MATCH_OVER with winner=3.
- state changes to 4'b0001 during COUNTDOWN → phase=0 the next cycle, all counters cleared. A tick_20Hz in IDLE has no effect.
